// File: rtl/pwm_wr_if.sv
// pwm_wr_if: single-cycle duty-write bus from the register logic into the PWM block
interface pwm_wr_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_duty;
    modport master (output wr_en, wr_ch, wr_duty);
    modport slave  (input wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared prescaler/period counter driving double-buffered, polarity-selectable PWM compares
module pwm_multi_channel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                mode,
    input  logic [CHANNELS-1:0] pol,
    pwm_wr_if.slave             wr,
    output logic [CHANNELS-1:0] pwm_o,
    output logic                period_start_o
);
    localparam logic [31:0] NCH = CHANNELS;

    logic [PRESC_W-1:0]  q;
    logic [WIDTH-1:0]    cnt;
    logic                dir_dn, mode_act, tick, bnd, turn;
    logic [WIDTH-1:0]    shadow     [CHANNELS];
    logic [WIDTH-1:0]    shadow_nxt [CHANNELS];
    logic [WIDTH-1:0]    active     [CHANNELS];
    logic [CHANNELS-1:0] raw;

    assign tick = en && q >= prescale;
    assign bnd  = tick && (mode_act ? dir_dn && cnt == WIDTH'(1) : &cnt);
    // center mode counts down once it has left MAX
    assign turn = mode_act && (dir_dn || &cnt);

    // active loads from shadow_nxt so a write on the boundary cycle wins
    always_comb begin
        shadow_nxt = shadow;
        if (wr.wr_en && 32'(wr.wr_ch) < NCH) shadow_nxt[wr.wr_ch] = wr.wr_duty;
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) raw[i] = cnt < active[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q              <= '0;
            cnt            <= '0;
            dir_dn         <= 1'b0;
            mode_act       <= 1'b0;
            shadow         <= '{default: '0};
            active         <= '{default: '0};
            pwm_o          <= '0;
            period_start_o <= 1'b0;
        end else begin
            shadow         <= shadow_nxt;
            period_start_o <= bnd;
            pwm_o          <= en ? raw ^ pol : pol;
            q              <= (tick || !en) ? '0 : q + 1'b1;
            if (!en || bnd) begin
                cnt      <= '0;
                dir_dn   <= 1'b0;
                mode_act <= mode;
                active   <= shadow_nxt;
            end else if (tick) begin
                cnt    <= turn ? cnt - 1'b1 : cnt + 1'b1;
                dir_dn <= turn;
            end
        end
    end
endmodule
